// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter
//   Measures period, high time and duty cycle of a slow single-bit signal in
//   clockin cycles. One measurement per start request; the result holds until
//   the next measurement completes.
//
// Ports
//   clockin    in   1      local clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   sigin      in   1      signal under test, asynchronous to clockin
//   start      in   1      one-cycle measurement request (ignored unless idle)
//   busy       out  1      measurement in progress
//   valid      out  1      one-cycle pulse, result outputs updated this cycle
//   period     out  CNT_W  cycles between consecutive rising edges
//   high_time  out  CNT_W  cycles from rising edge to falling edge
//   duty_pct   out  7      floor(100*high_time/period)
//   overflow   out  1      last measurement aborted on counter saturation
//
// State  | meaning
// IDLE   | waiting for start
// ARM    | waiting for the opening rising edge
// HIGH   | signal high, waiting for the falling edge
// LOW    | signal low, waiting for the closing rising edge
// DIV    | restoring divide of 100*high_time by period, one bit per cycle
// DONE   | result valid for one cycle

module duty_cycle_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             sigin,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic             overflow
);

  localparam int             NUM_W   = CNT_W + 7;
  localparam int             DCNT_W  = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DIV, DONE} state_t;

  state_t state, state_nx;

  logic             sig_s1, sig_s2, sig_hist;
  logic             rise, fall, sat, div_last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_reg, period_reg;
  logic [NUM_W-1:0] div_num;
  logic [CNT_W-1:0] div_rem;
  logic [DCNT_W-1:0] div_cnt;

  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] rem_diff, rem_nx;
  logic             q_bit;
  logic [NUM_W-1:0] num_nx;

  // input synchronizer and edge history
  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      sig_s1   <= 1'b0;
      sig_s2   <= 1'b0;
      sig_hist <= 1'b0;
    end else begin
      sig_s1   <= sigin;
      sig_s2   <= sig_s1;
      sig_hist <= sig_s2;
    end
  end

  assign rise     = sig_s2 & ~sig_hist;
  assign fall     = ~sig_s2 & sig_hist;
  assign sat      = (cnt == CNT_MAX);
  assign div_last = (div_cnt == DCNT_W'(NUM_W - 1));

  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    valid    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ARM;
      ARM: begin
        busy = 1'b1;
        if (sat)       state_nx = DONE;
        else if (rise) state_nx = HIGH;
      end
      HIGH: begin
        busy = 1'b1;
        if (sat)       state_nx = DONE;
        else if (fall) state_nx = LOW;
      end
      LOW: begin
        busy = 1'b1;
        if (sat)       state_nx = DONE;
        else if (rise) state_nx = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (div_last) state_nx = DONE;
      end
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One restoring-division step: shift the next numerator bit into the
  // remainder, subtract the divisor when it fits. The quotient bits are
  // shifted into div_num behind the consumed numerator bits.
  always_comb begin
    rem_sh   = {div_rem, div_num[NUM_W-1]};
    rem_diff = rem_sh[CNT_W-1:0] - period_reg;
    q_bit    = (rem_sh >= {1'b0, period_reg});
    rem_nx   = q_bit ? rem_diff : rem_sh[CNT_W-1:0];
    num_nx   = {div_num[NUM_W-2:0], q_bit};
  end

  // cnt holds (cycles since the opening rise) - 1, so captures add one.
  // Result outputs are loaded on the edge that enters DONE, so they change
  // exactly at the start of the valid cycle.
  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      high_reg   <= '0;
      period_reg <= '0;
      div_num    <= '0;
      div_rem    <= '0;
      div_cnt    <= '0;
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            overflow <= 1'b0;
          end
        end
        ARM, HIGH, LOW: begin
          if (sat) begin
            period    <= CNT_MAX;
            high_time <= CNT_MAX;
            duty_pct  <= '0;
            overflow  <= 1'b1;
          end else if (state == ARM) begin
            if (rise) cnt <= '0;
            else      cnt <= cnt + CNT_W'(1);
          end else if (state == HIGH) begin
            cnt <= cnt + CNT_W'(1);
            if (fall) high_reg <= cnt + CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (rise) begin
              period_reg <= cnt + CNT_W'(1);
              div_num    <= NUM_W'(high_reg) * NUM_W'(7'd100);
              div_rem    <= '0;
              div_cnt    <= '0;
            end
          end
        end
        DIV: begin
          div_num <= num_nx;
          div_rem <= rem_nx;
          div_cnt <= div_cnt + DCNT_W'(1);
          if (div_last) begin
            period    <= period_reg;
            high_time <= high_reg;
            duty_pct  <= num_nx[6:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
